// File: rtl/instr_encoder_loader_if.sv
// Operation stream and instruction-memory write bus of the instruction
// encoder/loader. The master side supplies symbolic operations and observes
// the memory writes; the slave side is the loader itself.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: turns symbolic RV32I operations into 32-bit
// instruction words and writes them to consecutive instruction-memory words,
// one cycle after each accepted operation. Immediate range problems, illegal
// operations and running out of memory are reported through sticky flags.
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  instr_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       word_count,
  output logic                  err_imm,
  output logic                  err_op,
  output logic                  err_full
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_ADDI = 4'd5,  OP_ANDI = 4'd6,  OP_ORI  = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8,  OP_SW   = 4'd9,  OP_BEQ  = 4'd10, OP_JAL  = 4'd11;
  localparam logic [3:0] OP_JALR = 4'd12, OP_LUI  = 4'd13, OP_AUIPC = 4'd14, OP_ILL = 4'd15;

  localparam logic [6:0] OPC_R     = 7'b0110011, OPC_I    = 7'b0010011, OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_BR   = 7'b1100011, OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111, OPC_LUI  = 7'b0110111, OPC_AUIPC = 7'b0010111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  // Field packing for every supported operation; out-of-range immediates are
  // simply truncated to the bits the format can hold.
  function automatic logic [31:0] encode_instr(input logic [3:0] op, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [31:0] imm);
    logic [31:0] w;
    w = NOP_WORD;
    case (op)
      OP_ADD:   w = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R};
      OP_SUB:   w = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R};
      OP_AND:   w = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_R};
      OP_OR:    w = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_R};
      OP_XOR:   w = {7'b0000000, rs2, rs1, 3'b100, rd, OPC_R};
      OP_ADDI:  w = {imm[11:0], rs1, 3'b000, rd, OPC_I};
      OP_ANDI:  w = {imm[11:0], rs1, 3'b111, rd, OPC_I};
      OP_ORI:   w = {imm[11:0], rs1, 3'b110, rd, OPC_I};
      OP_LW:    w = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
      OP_SW:    w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
      OP_BEQ:   w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BR};
      OP_JAL:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      OP_JALR:  w = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      OP_LUI:   w = {imm[31:12], rd, OPC_LUI};
      OP_AUIPC: w = {imm[31:12], rd, OPC_AUIPC};
      default:  w = NOP_WORD;
    endcase
    return w;
  endfunction

  // An immediate is bad when it does not sign-fit its format, is odd for a
  // branch/jump offset, or has low bits set for an upper-immediate op.
  function automatic logic imm_bad(input logic [3:0] op, input logic [31:0] imm);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_JALR:
        bad = (imm[31:11] != {21{imm[11]}});
      OP_BEQ:           bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
      OP_JAL:           bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
      OP_LUI, OP_AUIPC: bad = (imm[11:0] != 12'h000);
      default:          bad = 1'b0;
    endcase
    return bad;
  endfunction

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   waddr_r;
  logic [31:0]         wdata_r;
  logic                we_r, done_r;
  logic [ADDR_W:0]     wc_r;
  logic                err_imm_r, err_op_r, err_full_r;
  logic                ready_s, accept_s, full_hit_s;

  assign ready_s    = (state_r == ST_LOAD) && !start;
  assign accept_s   = bus.in_valid && ready_s;
  assign full_hit_s = (wc_r + (ADDR_W+1)'(1)) == DEPTH_CNT;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: start always (re)opens a session; in_last wins over filling up.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (start)                           state_s = ST_LOAD;
        else if (accept_s && bus.in_last)    state_s = ST_DRAIN;
        else if (accept_s && full_hit_s)     state_s = ST_FULL;
        else                                 state_s = ST_LOAD;
      end
      ST_DRAIN: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_FULL: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_FULL;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Write port, address/word counters and sticky error flags; start clears
  // the session while a write registered earlier still goes out uncounted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r     <= BASE;
      waddr_r    <= {ADDR_W{1'b0}};
      wdata_r    <= 32'h0000_0000;
      we_r       <= 1'b0;
      done_r     <= 1'b0;
      wc_r       <= {(ADDR_W+1){1'b0}};
      err_imm_r  <= 1'b0;
      err_op_r   <= 1'b0;
      err_full_r <= 1'b0;
    end else begin
      we_r   <= 1'b0;
      done_r <= 1'b0;
      if (start) begin
        addr_r     <= BASE;
        wc_r       <= {(ADDR_W+1){1'b0}};
        err_imm_r  <= 1'b0;
        err_op_r   <= 1'b0;
        err_full_r <= 1'b0;
      end else if (accept_s) begin
        we_r       <= 1'b1;
        waddr_r    <= addr_r;
        wdata_r    <= encode_instr(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
        addr_r     <= addr_r + ADDR_W'(1);
        wc_r       <= wc_r + (ADDR_W+1)'(1);
        done_r     <= bus.in_last;
        err_imm_r  <= err_imm_r | imm_bad(bus.in_op, bus.in_imm);
        err_op_r   <= err_op_r | (bus.in_op == OP_ILL);
        err_full_r <= err_full_r | (!bus.in_last && full_hit_s);
      end else begin
        addr_r <= addr_r;
      end
    end
  end

  assign bus.in_ready   = ready_s;
  assign bus.imem_we    = we_r;
  assign bus.imem_addr  = waddr_r;
  assign bus.imem_wdata = wdata_r;
  assign busy           = (state_r != ST_IDLE);
  assign done           = done_r;
  assign word_count     = wc_r;
  assign err_imm        = err_imm_r;
  assign err_op         = err_op_r;
  assign err_full       = err_full_r;

endmodule
